mem_port_arbiter: RTL and testbench

//   Shares one single-port synchronous RAM between the pipeline's IF stage (instruction fetch) and MEM stage (load/store).

---
 rtl/mem_port_arbiter.sv | 175 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous RAM between the IF stage
// (read-only fetch) and the MEM stage (load/store). One access at a time; MEM has
// priority, and a starvation counter forces IF to win after MAX_WAIT consecutive
// MEM grants while IF is waiting. All outputs are registered.
//
// Ports:
//   clock, reset                 rising-edge clock, asynchronous active-low reset
//   if_req/if_addr               IF read request, held until if_ready
//   if_rdata/if_ready            fetched word and one-cycle completion pulse
//   mem_req/mem_we/mem_addr/     MEM request (we=1 store), held until mem_ready
//   mem_wdata
//   mem_rdata/mem_ready          load data and one-cycle completion pulse
//   ram_en/ram_we/ram_addr/      RAM strobe (one cycle per access), write enable,
//   ram_wdata/ram_rdata          registered address/data, read data (LAT latency)
//   busy                         high whenever the FSM is not idle
module mem_port_arbiter #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned LAT      = 2,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);

  localparam int unsigned LatW  = $clog2(LAT + 1);
  localparam int unsigned WaitW = $clog2(MAX_WAIT + 1);
  localparam logic [LatW-1:0]  LatLoad = LatW'(LAT);
  localparam logic [WaitW-1:0] WaitMax = WaitW'(MAX_WAIT);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e            state_q, state_d;
  logic              owner_mem_q, owner_mem_d;
  logic [LatW-1:0]   lat_cnt_q, lat_cnt_d;
  logic [WaitW-1:0]  wait_cnt_q, wait_cnt_d;
  logic              ram_en_q, ram_en_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
  logic              if_ready_q, if_ready_d;
  logic              mem_ready_q, mem_ready_d;
  logic              busy_q, busy_d;

  logic grant_mem, grant_if;

  assign grant_mem = mem_req && (!if_req || (wait_cnt_q < WaitMax));
  assign grant_if  = if_req && !grant_mem;

  always_comb begin
    state_d     = state_q;
    owner_mem_d = owner_mem_q;
    lat_cnt_d   = lat_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    ram_en_d    = 1'b0;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    if_ready_d  = 1'b0;
    mem_ready_d = 1'b0;

    unique case (state_q)
      // The edge closing the ready cycle also arbitrates, so back-to-back
      // accesses lose no cycle; a requester drops or advances its req on ready.
      StIdle, StDone: begin
        state_d = StIdle;
        if (!if_req) wait_cnt_d = '0;
        if (grant_mem) begin
          state_d     = StIssue;
          owner_mem_d = 1'b1;
          ram_en_d    = 1'b1;
          ram_we_d    = mem_we;
          ram_addr_d  = mem_addr;
          ram_wdata_d = mem_wdata;
          if (if_req && (wait_cnt_q != WaitMax)) wait_cnt_d = wait_cnt_q + WaitW'(1);
        end else if (grant_if) begin
          state_d     = StIssue;
          owner_mem_d = 1'b0;
          ram_en_d    = 1'b1;
          ram_we_d    = 1'b0;
          ram_addr_d  = if_addr;
          wait_cnt_d  = '0;
        end
      end
      StIssue: begin
        if (owner_mem_q && ram_we_q) begin
          state_d     = StDone;
          mem_ready_d = 1'b1;
        end else begin
          state_d   = StWait;
          lat_cnt_d = LatLoad;
        end
      end
      StWait: begin
        lat_cnt_d = lat_cnt_q - LatW'(1);
        if (lat_cnt_q == LatW'(1)) begin
          state_d = StDone;
          if (owner_mem_q) begin
            mem_rdata_d = ram_rdata;
            mem_ready_d = 1'b1;
          end else begin
            if_rdata_d = ram_rdata;
            if_ready_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      owner_mem_q <= 1'b0;
      lat_cnt_q   <= '0;
      wait_cnt_q  <= '0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_mem_q <= owner_mem_d;
      lat_cnt_q   <= lat_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      if_ready_q  <= if_ready_d;
      mem_ready_q <= mem_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign if_rdata  = if_rdata_q;
  assign if_ready  = if_ready_q;
  assign mem_rdata = mem_rdata_q;
  assign mem_ready = mem_ready_q;
  assign ram_en    = ram_en_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (LAT=2, MAX_WAIT=2) with a word-indexed
// RAM model whose read data is valid only for the one cycle after LAT edges.
module tb_mem_port_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        mem_req = 1'b0;
  logic        mem_we = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        ram_en;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata = '0;
  logic        busy;

  int vectors = 0;
  int errors  = 0;

  mem_port_arbiter #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .LAT     (2),
    .MAX_WAIT(2)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_rdata (if_rdata),
    .if_ready (if_ready),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .ram_en   (ram_en),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata),
    .busy     (busy)
  );

  always #5 clock = ~clock;

  // RAM model: sample at edge N, data on ram_rdata after edge N+1, junk otherwise.
  logic [31:0] ram_mem [0:255];
  logic [31:0] rd_p1 = '0;
  logic        rd_v1 = 1'b0;

  initial begin
    for (int i = 0; i < 256; i++) ram_mem[i] = 32'h0100_0000 + i;
    ram_mem[1] = 32'h2010_0005;
  end

  always @(posedge clock) begin
    if (ram_en && ram_we) ram_mem[ram_addr[9:2]] <= ram_wdata;
    rd_v1     <= ram_en && !ram_we;
    rd_p1     <= ram_mem[ram_addr[9:2]];
    ram_rdata <= rd_v1 ? rd_p1 : 32'hBAD0_BAD0;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish, expected finish before 100000");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to #1 after the next rising edge: inputs driven and outputs sampled here.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  int       n_grants;
  logic     grant_is_if [0:5];
  int       ready_seen;
  int       cyc;

  initial begin
    // Reset state
    #3;
    chk("rst_ram_en", ram_en, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", {if_ready, mem_ready}, 2'b00);
    chk("rst_rdata", {if_rdata, mem_rdata}, 64'h0);
    tick();
    reset = 1'b1;
    tick();

    // 1) IF fetch of 0x4, granted at edge 0
    if_req = 1'b1; if_addr = 32'h4;
    tick();                                   // cycle 0
    chk("t1_ram_en_c0", {ram_en, ram_we}, 2'b10);
    chk("t1_ram_addr", ram_addr, 32'h4);
    chk("t1_busy", busy, 1'b1);
    tick();                                   // cycle 1
    chk("t1_ram_en_c1", ram_en, 1'b0);
    tick();                                   // cycle 2
    chk("t1_ready_c2", if_ready, 1'b0);
    tick();                                   // cycle 3
    chk("t1_ready_c3", if_ready, 1'b1);
    chk("t1_rdata", if_rdata, 32'h2010_0005);
    chk("t1_mem_ready", mem_ready, 1'b0);
    if_req = 1'b0;
    tick();                                   // cycle 4
    chk("t1_ready_c4", if_ready, 1'b0);
    chk("t1_busy_c4", busy, 1'b0);

    // 2) MEM store 0xDEADBEEF to 0x10
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h10; mem_wdata = 32'hDEAD_BEEF;
    tick();                                   // cycle 0
    chk("t2_ram_en_we", {ram_en, ram_we}, 2'b11);
    chk("t2_ram_addr", ram_addr, 32'h10);
    chk("t2_ram_wdata", ram_wdata, 32'hDEAD_BEEF);
    tick();                                   // cycle 1
    chk("t2_ram_en_off", {ram_en, ram_we}, 2'b00);
    chk("t2_mem_ready", mem_ready, 1'b1);
    chk("t2_ram_word4", ram_mem[4], 32'hDEAD_BEEF);
    mem_req = 1'b0; mem_we = 1'b0;
    tick();                                   // cycle 2
    chk("t2_ready_off", mem_ready, 1'b0);
    chk("t2_busy", busy, 1'b0);
    chk("t2_hold_wdata", ram_wdata, 32'hDEAD_BEEF);

    // 3) Simultaneous IF (0x4) and MEM load (0x10): MEM first, IF at edge 4
    if_req = 1'b1; if_addr = 32'h4;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h10;
    tick();                                   // cycle 0
    chk("t3_first_addr", ram_addr, 32'h10);
    chk("t3_first_en", {ram_en, ram_we}, 2'b10);
    tick(); tick(); tick();                   // cycle 3
    chk("t3_mem_ready", mem_ready, 1'b1);
    chk("t3_mem_rdata", mem_rdata, 32'hDEAD_BEEF);
    chk("t3_if_rdata_hold", if_rdata, 32'h2010_0005);
    mem_req = 1'b0;
    tick();                                   // cycle 4
    chk("t3_if_en_c4", ram_en, 1'b1);
    chk("t3_if_addr_c4", ram_addr, 32'h4);
    tick(); tick();                           // cycle 6
    chk("t3_if_ready_c6", if_ready, 1'b0);
    tick();                                   // cycle 7
    chk("t3_if_ready_c7", if_ready, 1'b1);
    chk("t3_if_rdata", if_rdata, 32'h2010_0005);
    chk("t3_mem_rdata_hold", mem_rdata, 32'hDEAD_BEEF);
    if_req = 1'b0;
    tick();
    chk("t3_busy_end", busy, 1'b0);

    // 4) Both held: MAX_WAIT=2 gives MEM, MEM, IF, MEM, MEM, IF
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h100; mem_wdata = 32'h1234_5678;
    if_req = 1'b1; if_addr = 32'h200;
    n_grants = 0;
    for (int c = 0; c < 40 && n_grants < 6; c++) begin
      tick();
      if (ram_en) begin
        grant_is_if[n_grants] = (ram_addr == 32'h200);
        n_grants++;
      end
    end
    mem_req = 1'b0; if_req = 1'b0; mem_we = 1'b0;
    chk("t4_grant_count", n_grants, 6);
    if (n_grants == 6) begin
      chk("t4_order", {grant_is_if[0], grant_is_if[1], grant_is_if[2],
                       grant_is_if[3], grant_is_if[4], grant_is_if[5]}, 6'b001001);
    end
    cyc = 0;
    while (busy && cyc < 20) begin
      tick();
      cyc++;
    end
    chk("t4_drain", busy, 1'b0);
    tick();

    // 5) Reset during WAIT: outputs clear at once, no ready pulse, then normal service
    if_req = 1'b1; if_addr = 32'h4;
    tick();                                   // cycle 0 (ISSUE)
    tick();                                   // cycle 1 (WAIT)
    #2 reset = 1'b0;
    #1;
    chk("t5_rst_busy", busy, 1'b0);
    chk("t5_rst_ram", {ram_en, ram_we, ram_addr}, 34'h0);
    chk("t5_rst_rdata", {if_rdata, mem_rdata}, 64'h0);
    if_req = 1'b0;
    ready_seen = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (if_ready || mem_ready) ready_seen++;
    end
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (if_ready || mem_ready) ready_seen++;
    end
    chk("t5_no_ready", ready_seen, 0);
    if_req = 1'b1; if_addr = 32'h10;
    tick();                                   // cycle 0
    chk("t5_fresh_en", ram_en, 1'b1);
    tick(); tick(); tick();                   // cycle 3
    chk("t5_fresh_ready", if_ready, 1'b1);
    chk("t5_fresh_rdata", if_rdata, 32'hDEAD_BEEF);
    if_req = 1'b0;
    tick();

    // 6) IF drops req during WAIT: ready still pulses once, then idle
    if_req = 1'b1; if_addr = 32'h4;
    tick();                                   // cycle 0
    tick();                                   // cycle 1
    if_req = 1'b0;
    tick();                                   // cycle 2
    chk("t6_ready_c2", if_ready, 1'b0);
    tick();                                   // cycle 3
    chk("t6_ready_c3", if_ready, 1'b1);
    chk("t6_busy_c3", busy, 1'b1);
    chk("t6_rdata", if_rdata, 32'h2010_0005);
    tick();                                   // cycle 4
    chk("t6_ready_c4", if_ready, 1'b0);
    chk("t6_busy_c4", busy, 1'b0);
    tick();
    chk("t6_no_regrant", ram_en, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
